// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_ctrl
// Purpose  : UART transmit framer. Accepts one byte per request and drives an
//            external 8-bit LSB-first serializer, muxing start, data, optional
//            parity and stop bits onto the serial line, one bit per clock.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            P_DATA[7:0]     - byte to send, sampled on accept
//            data_valid      - request strobe, honoured only in IDLE
//            PAR_EN, PAR_TYP - parity enable / type (0 even, 1 odd), sampled on accept
//            ser_done        - serializer has shifted its 8th bit
//            ser_data        - serializer's current data bit
//            ser_en          - serializer shift enable (START and DATA)
//            ser_p_data[7:0] - serializer load value
//            TX_OUT          - serial line, idles high
//            busy            - high outside IDLE
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_ctrl #(
   parameter int STOP_BITS = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] P_DATA,
   input  logic       data_valid,
   input  logic       PAR_EN,
   input  logic       PAR_TYP,
   input  logic       ser_done,
   input  logic       ser_data,
   output logic       ser_en,
   output logic [7:0] ser_p_data,
   output logic       TX_OUT,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   // Value of the 1-bit stop counter during the final stop cycle.
   localparam logic STOP_LAST = (STOP_BITS == 2);

   state_t     state;
   state_t     state_next;
   logic [7:0] data_lat;
   logic       par_en_lat;
   logic       par_bit;
   logic       stop_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Request capture and stop-bit counting.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_lat   <= 8'h00;
         par_en_lat <= 1'b0;
         par_bit    <= 1'b0;
         stop_cnt   <= 1'b0;
      end else begin
         if (state == IDLE && data_valid) begin
            data_lat   <= P_DATA;
            par_en_lat <= PAR_EN;
            par_bit    <= (^P_DATA) ^ PAR_TYP;
         end
         if (state == STOP) begin
            stop_cnt <= (stop_cnt == STOP_LAST) ? 1'b0 : ~stop_cnt;
         end else begin
            stop_cnt <= 1'b0;
         end
      end
   end

   always_comb begin
      state_next = state;
      TX_OUT     = 1'b1;
      ser_en     = 1'b0;
      busy       = 1'b1;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (data_valid) begin
               state_next = START;
            end
         end
         START: begin
            TX_OUT     = 1'b0;
            ser_en     = 1'b1;
            state_next = DATA;
         end
         DATA: begin
            TX_OUT = ser_data;
            ser_en = 1'b1;
            // ser_done marks bit 7 on the line: this is the last data cycle.
            if (ser_done) begin
               state_next = par_en_lat ? PARITY : STOP;
            end
         end
         PARITY: begin
            TX_OUT     = par_bit;
            state_next = STOP;
         end
         STOP: begin
            if (stop_cnt == STOP_LAST) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // In IDLE the serializer (loading while ser_en is low) sees the live byte,
   // so it holds the accepted byte right after the accept edge.
   assign ser_p_data = (state == IDLE) ? P_DATA : data_lat;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_ctrl
// Purpose  : Self-checking bench for uart_tx_ctrl. Two instances (one and two
//            stop bits), each paired with a behavioural model of the 8-bit
//            LSB-first serializer. Expected line bits are queued when a
//            request is driven and popped as the frame appears on TX_OUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  P_DATA;
   logic [1:0]  dv;
   logic        PAR_EN;
   logic        PAR_TYP;
   logic        stray;
   wire  [1:0]  tx;
   wire  [1:0]  busy;
   wire  [1:0]  sen;
   wire  [15:0] spd;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [1:0]  exp_q[$];   // {ser_en, TX_OUT} per frame cycle

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [7:0] sh    = 8'h00;
      logic [3:0] cnt   = 4'd0;
      logic       sd    = 1'b0;
      logic       sdone = 1'b0;
      logic       en_w;
      logic       tx_w;
      logic       busy_w;
      logic [7:0] spd_w;

      uart_tx_ctrl #(.STOP_BITS(g + 1)) u_dut (
         .clk        (clk),
         .rst        (rst),
         .P_DATA     (P_DATA),
         .data_valid (dv[g]),
         .PAR_EN     (PAR_EN),
         .PAR_TYP    (PAR_TYP),
         .ser_done   (sdone | stray),
         .ser_data   (sd),
         .ser_en     (en_w),
         .ser_p_data (spd_w),
         .TX_OUT     (tx_w),
         .busy       (busy_w)
      );

      assign tx[g]          = tx_w;
      assign busy[g]        = busy_w;
      assign sen[g]         = en_w;
      assign spd[g*8 +: 8]  = spd_w;

      // Serializer model: loads while disabled; each enabled edge presents
      // the next bit, and flags done alongside bit 7.
      always @(posedge clk) begin
         if (!en_w) begin
            sh    <= spd_w;
            cnt   <= 4'd0;
            sd    <= 1'b0;
            sdone <= 1'b0;
         end else begin
            sd    <= sh[0];
            sh    <= sh >> 1;
            cnt   <= cnt + 4'd1;
            sdone <= (cnt == 4'd7);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic check_idle(input int s, input string tag);
      chk({tag, "_busy"}, 8'(busy[s]), 8'd0);
      chk({tag, "_tx"},   8'(tx[s]),   8'd1);
      chk({tag, "_sen"},  8'(sen[s]),  8'd0);
   endtask

   task automatic push_frame(input int s, input logic [7:0] d, input logic pe, input logic pt);
      exp_q.push_back(2'b10);
      for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, d[i]});
      if (pe) exp_q.push_back({1'b0, (^d) ^ pt});
      for (int i = 0; i <= s; i++) exp_q.push_back(2'b01);
   endtask

   task automatic send(input int s, input logic [7:0] d, input logic pe, input logic pt);
      P_DATA  = d;
      PAR_EN  = pe;
      PAR_TYP = pt;
      dv[s]   = 1'b1;
      tick();
      dv[s]   = 1'b0;
   endtask

   // Called in the START cycle; checks every frame cycle then the idle cycle.
   task automatic drain(input int s, input logic [7:0] d, input string tag);
      logic [1:0] e;
      int         k;
      chk({tag, "_latched"}, spd[s*8 +: 8], d);
      k = 0;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk($sformatf("%s_c%0d_tx", tag, k),   8'(tx[s]),   8'(e[0]));
         chk($sformatf("%s_c%0d_sen", tag, k),  8'(sen[s]),  8'(e[1]));
         chk($sformatf("%s_c%0d_busy", tag, k), 8'(busy[s]), 8'd1);
         k++;
         tick();
      end
      check_idle(s, {tag, "_end"});
   endtask

   initial begin
      rst     = 1'b1;
      dv      = 2'b11;
      P_DATA  = 8'hA5;
      PAR_EN  = 1'b0;
      PAR_TYP = 1'b0;
      stray   = 1'b0;

      // Reset held with requests pending: nothing may start.
      tick();
      check_idle(0, "rst0_a"); check_idle(1, "rst1_a");
      tick();
      check_idle(0, "rst0_b"); check_idle(1, "rst1_b");
      rst = 1'b0;
      dv  = 2'b00;
      tick();
      check_idle(0, "rst0_c"); check_idle(1, "rst1_c");

      // Stray ser_done while idle.
      stray = 1'b1;
      tick();
      stray = 1'b0;
      check_idle(0, "stray");

      // 8N1 and parity variants.
      push_frame(0, 8'hA5, 1'b0, 1'b0); send(0, 8'hA5, 1'b0, 1'b0); drain(0, 8'hA5, "n1_a5");
      push_frame(0, 8'hA5, 1'b1, 1'b0); send(0, 8'hA5, 1'b1, 1'b0); drain(0, 8'hA5, "e1_a5");
      push_frame(0, 8'hA5, 1'b1, 1'b1); send(0, 8'hA5, 1'b1, 1'b1); drain(0, 8'hA5, "o1_a5");
      push_frame(0, 8'h07, 1'b1, 1'b0); send(0, 8'h07, 1'b1, 1'b0); drain(0, 8'h07, "e1_07");

      // Request held through the frame with inputs changing mid-frame.
      push_frame(0, 8'h3C, 1'b0, 1'b0);
      P_DATA  = 8'h3C;
      PAR_EN  = 1'b0;
      PAR_TYP = 1'b0;
      dv[0]   = 1'b1;
      tick();
      P_DATA  = 8'hFF;
      PAR_EN  = 1'b1;
      drain(0, 8'h3C, "hold1");
      chk("hold_idle_passthru", spd[7:0], 8'hFF);
      push_frame(0, 8'hFF, 1'b1, 1'b0);
      tick();
      dv[0] = 1'b0;
      drain(0, 8'hFF, "hold2");

      // Reset in DATA cycle 4, then a clean frame.
      send(0, 8'h5A, 1'b0, 1'b0);
      repeat (4) tick();
      chk("mid_in_data", 8'(sen[0]), 8'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_idle(0, "mid_rst");
      tick();
      check_idle(0, "mid_rst2");
      push_frame(0, 8'h81, 1'b0, 1'b0); send(0, 8'h81, 1'b0, 1'b0); drain(0, 8'h81, "after_rst");

      // Two stop bits, even parity.
      check_idle(1, "s2_pre");
      push_frame(1, 8'h00, 1'b1, 1'b0); send(1, 8'h00, 1'b1, 1'b0); drain(1, 8'h00, "e2_00");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

UART transmit controller that frames one byte per request. It accepts a parallel byte with a valid strobe, drives the team's 8-bit LSB-first serializer (`ser_en`/`ser_done`/`ser_data`), and muxes start, data, optional parity and stop bits onto the serial line. It sits directly upstream of the serializer, between the host-side data source and the TX pin.

## Interface

- `STOP_BITS`, default 1: stop-bit cycles per frame; legal values are 1 or 2.
- `clk`  in  1  the single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `P_DATA`  in  8  byte to transmit; sampled only on accept.
- `data_valid`  in  1  request strobe; accepted only in IDLE.
- `PAR_EN`  in  1  parity enable; sampled on accept.
- `PAR_TYP`  in  1  parity type, 0 = even, 1 = odd; sampled on accept.
- `ser_done`  in  1  from serializer; high once 8 bits have been shifted.
- `ser_data`  in  1  from serializer; current data bit.
- `ser_en`  out  1  to serializer; high in START and DATA only.
- `ser_p_data`  out  8  to serializer: `P_DATA` while in IDLE, latched byte otherwise.
- `TX_OUT`  out  1  serial line; idles high.
- `busy`  out  1  high in every state except IDLE.

## Operation

- **States:** IDLE, START, DATA, PARITY, STOP.
- **IDLE**
  - Drives `TX_OUT`=1, `ser_en`=0, `busy`=0.
  - On `data_valid`=1, accepts: latches `P_DATA`, `PAR_EN` and `PAR_TYP`, and computes the parity bit. Next state is START.
- **Serializer load:** `ser_p_data` passes `P_DATA` through in IDLE, so the serializer, which loads whenever `ser_en` is low, captures the accepted byte on the accept edge.
- **START**
  - Drives `TX_OUT`=0 and `ser_en`=1.
  - The serializer shifts out bit 0 on this edge.
  - Next state is DATA unconditionally.
- **DATA**
  - Drives `TX_OUT`=`ser_data` and `ser_en`=1.
  - On `ser_done`=1, the current cycle (bit 7) is the last data cycle. Next state is PARITY if the latched `PAR_EN`=1, else STOP.
  - With the team serializer this gives exactly 8 DATA cycles: bit 0 through bit 7, LSB first.
- **PARITY**
  - Drives `TX_OUT`=parity bit and `ser_en`=0.
  - Parity bit = XOR of the 8 latched data bits, then XOR with the latched `PAR_TYP`.
  - Lasts 1 cycle; next state is STOP.
- **STOP**
  - Drives `TX_OUT`=1 and `ser_en`=0.
  - Lasts `STOP_BITS` cycles, counted with a 1-bit counter; next state is IDLE.
- **Output decode:** `TX_OUT`, `ser_en` and `busy` are decoded combinationally from the state register (Moore), except in DATA, where `TX_OUT` passes `ser_data` through.
- **Changes to unsampled inputs:** `P_DATA`, `PAR_EN` and `PAR_TYP` changing after accept have no effect on the frame in flight.
- **`data_valid` while busy:** ignored and not queued; the source must hold or re-present the request once `busy`=0.
- **Stray `ser_done`:** `ser_done` high outside DATA is ignored.

## Timing

- **Reset values:** state IDLE, `TX_OUT`=1, `busy`=0, `ser_en`=0, stop counter 0, latched byte 0x00.
- **Reset mid-frame:** `rst` sampled high in any state → IDLE on that edge. The frame is aborted and the line returns high the next cycle. `ser_en` drops, so the serializer reloads.
- **Accept latency:** `data_valid` seen at edge N → START (line 0) in cycle N+1, and `busy`=1 from cycle N+1.
- **Frame length** (cycles of `busy`=1): 1 + 8 + `PAR_EN` + `STOP_BITS`. That is 10 for 8N1, 11 for 8E1/8O1, and 12 for 8E2.
- **Back-to-back:** a request cannot be accepted in the last STOP cycle. The minimum gap is one IDLE cycle, so frames repeat at frame length + 1.
- **Simultaneous `rst` and `data_valid`:** reset wins; the request is not accepted.
- **One bit per clock:** each bit lasts exactly 1 `clk` cycle. Baud scaling is done by clock-enabling this block together with the serializer, not internally.

## Test plan

- **Reset:** assert `rst` for 2 cycles with `data_valid`=1 → `TX_OUT`=1, `busy`=0, `ser_en`=0 throughout, and no frame starts.
- **8N1, 0xA5:** `PAR_EN`=0, `P_DATA`=0xA5, 1-cycle `data_valid` → `TX_OUT` is 0,1,0,1,0,0,1,0,1,1 over 10 cycles; `busy` is high for exactly those 10 cycles, then `TX_OUT`=1.
- **Parity values**
  - `PAR_EN`=1, `PAR_TYP`=0, 0xA5 → parity bit 0 (frame 0,1,0,1,0,0,1,0,1,0,1).
  - `PAR_TYP`=1, 0xA5 → parity bit 1.
  - Even parity, 0x07 → parity bit 1.
- **Busy handling:** hold `data_valid`=1 continuously with 0x3C then 0xFF presented mid-frame → the first frame carries 0x3C unchanged. After one IDLE cycle the second frame starts with the current `P_DATA`.
- **Reset mid-frame:** assert `rst` in DATA cycle 4 → `TX_OUT`=1 and `busy`=0 on the next cycle. A new 0x81 request afterwards transmits correctly, with 8 DATA cycles.
- **Two stop bits:** `STOP_BITS`=2, 0x00, `PAR_EN`=1, even → 12-cycle frame ending 0,1,1, with parity 0 followed by two stop bits.
